// File: rtl/cache_ctrl_if.sv
// Bundle of every non-clock signal between cache_ctrl, the CPU, the backing
// memory and the tag/valid/data RAMs. Modport master is the controller side;
// modport slave is the CPU/memory/RAM environment.
interface cache_ctrl_if #(
    parameter int INDEX_W = 12,
    parameter int TAG_W   = 18
);
    // CPU side
    logic               cpu_req;
    logic               cpu_we;
    logic [31:0]        cpu_addr;
    logic [31:0]        cpu_wdata;
    logic               cpu_flush;
    logic [31:0]        cpu_rdata;
    logic               cpu_ready;
    logic               busy;
    // Backing memory
    logic               mem_req;
    logic               mem_we;
    logic [31:0]        mem_addr;
    logic [31:0]        mem_wdata;
    logic [31:0]        mem_rdata;
    logic               mem_ack;
    // Tag / valid / data RAMs (asynchronous read at idx)
    logic [INDEX_W-1:0] idx;
    logic               tag_we;
    logic               valid_we;
    logic               data_we;
    logic [TAG_W-1:0]   tag_wdata;
    logic               valid_wdata;
    logic [31:0]        data_wdata;
    logic [TAG_W-1:0]   tag_rdata;
    logic               valid_rdata;
    logic [31:0]        data_rdata;
    // Statistics
    logic [15:0]        hit_cnt;
    logic [15:0]        miss_cnt;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_flush,
        output cpu_rdata, cpu_ready, busy,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack,
        output idx, tag_we, valid_we, data_we, tag_wdata, valid_wdata, data_wdata,
        input  tag_rdata, valid_rdata, data_rdata,
        output hit_cnt, miss_cnt
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_flush,
        input  cpu_rdata, cpu_ready, busy,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack,
        input  idx, tag_we, valid_we, data_we, tag_wdata, valid_wdata, data_wdata,
        output tag_rdata, valid_rdata, data_rdata,
        input  hit_cnt, miss_cnt
    );
endinterface

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller with flush.
// Latency: read hit completes 2 cycles after the accepting edge; misses/writes wait on mem_ack.
// Backpressure: requests are taken only in IDLE (busy=0); memory stalls hold mem_req until mem_ack.
// Ports: clk, reset_n (async active-low) and cache_ctrl_if.master carrying the
// CPU request/response, backing-memory handshake, RAM ports and hit/miss counters.
module cache_ctrl #(
    parameter int INDEX_W = 12,
    parameter int TAG_W   = 18
) (
    input  logic          clk,
    input  logic          reset_n,
    cache_ctrl_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE, COMPARE, MEM_RD, FILL, MEM_WR, DONE, FLUSH
    } state_t;

    state_t             state_q, state_d;
    logic [29:0]        addr_q, addr_d;     // word address
    logic               we_q, we_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        fill_q, fill_d;     // data captured from memory on a read miss
    logic [31:0]        rdata_q, rdata_d;
    logic [INDEX_W-1:0] sweep_q, sweep_d;
    logic [15:0]        hit_q, hit_d;
    logic [15:0]        miss_q, miss_d;

    logic [INDEX_W-1:0] lat_idx;
    logic [TAG_W-1:0]   lat_tag;
    logic               hit;
    logic               unused_addr_lsb;

    assign lat_idx = addr_q[INDEX_W-1:0];
    assign lat_tag = addr_q[INDEX_W +: TAG_W];
    assign hit     = bus.valid_rdata && (bus.tag_rdata == lat_tag);

    // Byte-offset bits carry no information for a word cache.
    assign unused_addr_lsb = &{1'b0, bus.cpu_addr[1:0]};

    assign bus.cpu_rdata = rdata_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.mem_addr  = {addr_q, 2'b00};
    assign bus.mem_wdata = wdata_q;
    assign bus.hit_cnt   = hit_q;
    assign bus.miss_cnt  = miss_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FLUSH;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            fill_q  <= '0;
            rdata_q <= '0;
            sweep_q <= '0;
            hit_q   <= '0;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            fill_q  <= fill_d;
            rdata_q <= rdata_d;
            sweep_q <= sweep_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        we_d            = we_q;
        wdata_d         = wdata_q;
        fill_d          = fill_q;
        rdata_d         = rdata_q;
        sweep_d         = sweep_q;
        hit_d           = hit_q;
        miss_d          = miss_q;
        bus.idx         = lat_idx;
        bus.tag_we      = 1'b0;
        bus.valid_we    = 1'b0;
        bus.data_we     = 1'b0;
        bus.tag_wdata   = lat_tag;
        bus.valid_wdata = 1'b0;
        bus.data_wdata  = wdata_q;
        bus.mem_req     = 1'b0;
        bus.mem_we      = 1'b0;
        bus.cpu_ready   = 1'b0;

        case (state_q)
            IDLE: begin
                // Present the incoming index so the RAMs are already reading it.
                bus.idx = bus.cpu_addr[INDEX_W+1:2];
                sweep_d = '0;
                if (bus.cpu_flush) begin
                    state_d = FLUSH;
                end else if (bus.cpu_req) begin
                    addr_d  = bus.cpu_addr[31:2];
                    we_d    = bus.cpu_we;
                    wdata_d = bus.cpu_wdata;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (hit) begin
                    hit_d = (hit_q == 16'hFFFF) ? hit_q : hit_q + 16'd1;
                end else begin
                    miss_d = (miss_q == 16'hFFFF) ? miss_q : miss_q + 16'd1;
                end
                if (we_q) begin
                    // Write-through: update the line only if it is present.
                    bus.data_we = hit;
                    state_d     = MEM_WR;
                end else if (hit) begin
                    rdata_d = bus.data_rdata;
                    state_d = DONE;
                end else begin
                    state_d = MEM_RD;
                end
            end
            MEM_RD: begin
                bus.mem_req = 1'b1;
                if (bus.mem_ack) begin
                    fill_d  = bus.mem_rdata;
                    state_d = FILL;
                end
            end
            FILL: begin
                bus.tag_we      = 1'b1;
                bus.valid_we    = 1'b1;
                bus.data_we     = 1'b1;
                bus.valid_wdata = 1'b1;
                bus.data_wdata  = fill_q;
                rdata_d         = fill_q;
                state_d         = DONE;
            end
            MEM_WR: begin
                bus.mem_req = 1'b1;
                bus.mem_we  = 1'b1;
                if (bus.mem_ack) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.cpu_ready = 1'b1;
                state_d       = IDLE;
            end
            FLUSH: begin
                bus.idx      = sweep_q;
                bus.valid_we = 1'b1;
                if (sweep_q == '1) begin
                    sweep_d = '0;
                    state_d = IDLE;
                end else begin
                    sweep_d = sweep_q + 1'b1;
                end
            end
            default: begin
                // Unreachable encoding: recover through a full invalidation.
                sweep_d = '0;
                state_d = FLUSH;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_ctrl.sv
module tb_cache_ctrl;

    localparam int IW = 12;
    localparam int TW = 18;
    localparam int SWEEP = 1 << IW;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    cache_ctrl_if #(.INDEX_W(IW), .TAG_W(TW)) bus();

    cache_ctrl #(.INDEX_W(IW), .TAG_W(TW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Tag/valid/data RAMs: asynchronous read, synchronous write
    logic [TW-1:0] tag_ram   [SWEEP];
    logic          valid_ram [SWEEP];
    logic [31:0]   data_ram  [SWEEP];
    assign bus.tag_rdata   = tag_ram[bus.idx];
    assign bus.valid_rdata = valid_ram[bus.idx];
    assign bus.data_rdata  = data_ram[bus.idx];
    always @(posedge clk) begin
        if (bus.tag_we)   tag_ram[bus.idx]   <= bus.tag_wdata;
        if (bus.valid_we) valid_ram[bus.idx] <= bus.valid_wdata;
        if (bus.data_we)  data_ram[bus.idx]  <= bus.data_wdata;
    end

    int n_chk = 0;
    int n_fail = 0;

    // Reference models: backing memory, cache residency, expected counters
    logic [31:0]   memm [logic [29:0]];
    bit            mvalid [int];
    logic [TW-1:0] mtag [int];
    int            e_hit = 0;
    int            e_miss = 0;
    logic [31:0]   exp_q [$];

    typedef struct {
        logic        ready;
        int          lat;
        logic [31:0] rdata;
        logic        mem;
        logic        mem_we;
        logic [31:0] mem_addr;
        logic        unstable;
        logic        cmp_we;
        logic        fill;
        int          fill_idx;
        logic [TW-1:0] fill_tag;
        logic [31:0] fill_dat;
        logic        after_busy;
        logic        after_ready;
    } obs_t;

    function automatic int f_idx(input logic [31:0] a);
        return int'(a[IW+1:2]);
    endfunction

    function automatic logic [TW-1:0] f_tag(input logic [31:0] a);
        return a[31:IW+2];
    endfunction

    function automatic logic [31:0] mem_get(input logic [31:0] a);
        if (memm.exists(a[31:2])) return memm[a[31:2]];
        return {a[31:2], 2'b11} ^ 32'h5A5A_0000;
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        int i;
        i = f_idx(a);
        return mvalid.exists(i) && mvalid[i] && (mtag[i] == f_tag(a));
    endfunction

    // Drives one CPU access and plays the memory; records what the DUT did.
    // ack_dly = number of mem_req cycles before mem_ack (0 = never).
    task automatic run_access(input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input int ack_dly,
                              output obs_t o);
        int guard;
        int cyc;
        int reqc;
        logic [31:0] mwd;
        o.ready = 0; o.lat = 0; o.rdata = 0; o.mem = 0; o.mem_we = 0;
        o.mem_addr = 0; o.unstable = 0; o.cmp_we = 0; o.fill = 0;
        o.fill_idx = -1; o.fill_tag = 0; o.fill_dat = 0;
        o.after_busy = 1; o.after_ready = 1;
        mwd = 0;
        guard = 0;
        while (bus.busy && guard < 10000) begin
            @(posedge clk); #1; guard++;
        end
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
        @(posedge clk); #1;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
        cyc = 1;
        reqc = 0;
        while (cyc < 200) begin
            if (bus.data_we && !bus.tag_we) o.cmp_we = 1;
            if (bus.tag_we) begin
                o.fill = 1; o.fill_idx = int'(bus.idx);
                o.fill_tag = bus.tag_wdata; o.fill_dat = bus.data_wdata;
            end
            if (bus.mem_req) begin
                if (reqc == 0) begin
                    o.mem = 1; o.mem_we = bus.mem_we; o.mem_addr = bus.mem_addr;
                    mwd = bus.mem_wdata;
                end else if (bus.mem_we !== o.mem_we || bus.mem_addr !== o.mem_addr ||
                             bus.mem_wdata !== mwd) begin
                    o.unstable = 1;
                end
                reqc++;
                if (reqc == ack_dly) begin
                    if (bus.mem_we) memm[bus.mem_addr[31:2]] = bus.mem_wdata;
                    bus.mem_rdata = mem_get(bus.mem_addr);
                    bus.mem_ack = 1'b1;
                end
            end
            if (bus.cpu_ready) begin
                o.ready = 1; o.lat = cyc; o.rdata = bus.cpu_rdata;
                break;
            end
            @(posedge clk); #1;
            bus.mem_ack = 1'b0;
            cyc++;
        end
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        o.after_busy = bus.busy;
        o.after_ready = bus.cpu_ready;
    endtask

    // Scoreboard front end: predicts with the models, queues read data, drives.
    task automatic drive_scored(input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input int dly,
                                output obs_t o, output bit was_hit);
        was_hit = model_hit(addr);
        if (!we) exp_q.push_back(mem_get(addr));
        if (was_hit) e_hit++; else e_miss++;
        run_access(we, addr, wdata, dly, o);
        if (!we && !was_hit) begin
            mvalid[f_idx(addr)] = 1'b1;
            mtag[f_idx(addr)] = f_tag(addr);
        end
    endtask

    task automatic test_reset();
        int cnt, vwe_err, idx_err, rdy_err;
        #1 reset_n = 1'b0;
        #2;
        n_chk++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b want 1", bus.busy); end
        n_chk++; if (bus.cpu_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", bus.cpu_ready); end
        n_chk++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", bus.mem_req); end
        n_chk++; if (bus.cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", bus.cpu_rdata); end
        n_chk++; if (bus.hit_cnt !== 16'h0 || bus.miss_cnt !== 16'h0) begin
            n_fail++; $display("FAIL reset_cnt: got hit %0d miss %0d want 0 0", bus.hit_cnt, bus.miss_cnt); end
        repeat (3) @(posedge clk);
        @(negedge clk); reset_n = 1'b1;
        cnt = 0; vwe_err = 0; idx_err = 0; rdy_err = 0;
        while (bus.busy && cnt < 5000) begin
            if (bus.valid_we !== 1'b1 || bus.valid_wdata !== 1'b0) vwe_err++;
            if (bus.idx !== IW'(cnt)) idx_err++;
            if (bus.cpu_ready !== 1'b0 || bus.mem_req !== 1'b0) rdy_err++;
            @(posedge clk); #1; cnt++;
        end
        n_chk++; if (cnt != SWEEP) begin n_fail++; $display("FAIL sweep_len: got %0d want %0d", cnt, SWEEP); end
        n_chk++; if (vwe_err != 0) begin n_fail++; $display("FAIL sweep_valid_we: got %0d bad cycles want 0", vwe_err); end
        n_chk++; if (idx_err != 0) begin n_fail++; $display("FAIL sweep_idx: got %0d bad cycles want 0", idx_err); end
        n_chk++; if (rdy_err != 0) begin n_fail++; $display("FAIL sweep_quiet: got %0d bad cycles want 0", rdy_err); end
    endtask

    task automatic test_read_miss_fill();
        obs_t o; bit h; logic [31:0] a; logic [31:0] exp;
        a = 32'h0000_1004;
        memm[a[31:2]] = 32'hDEAD_BEEF;
        drive_scored(1'b0, a, 32'h0, 3, o, h);
        n_chk++; if (o.ready !== 1'b1) begin n_fail++; $display("FAIL miss_ready: got %b want 1", o.ready); end
        n_chk++; exp = exp_q.pop_front(); if (o.rdata !== exp) begin n_fail++; $display("FAIL miss_rdata: got %h want %h", o.rdata, exp); end
        n_chk++; if (o.lat != 6) begin n_fail++; $display("FAIL miss_latency: got %0d want 6", o.lat); end
        n_chk++; if (o.mem !== 1'b1 || o.mem_we !== 1'b0 || o.mem_addr !== a) begin
            n_fail++; $display("FAIL miss_mem: got req %b we %b addr %h want 1 0 %h", o.mem, o.mem_we, o.mem_addr, a); end
        n_chk++; if (o.fill !== 1'b1 || o.fill_idx != f_idx(a) || o.fill_tag !== f_tag(a) || o.fill_dat !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL fill: got %b idx %0d tag %h dat %h want 1 %0d %h deadbeef",
                               o.fill, o.fill_idx, o.fill_tag, o.fill_dat, f_idx(a), f_tag(a)); end
        n_chk++; if (bus.miss_cnt !== 16'(e_miss) || bus.hit_cnt !== 16'(e_hit)) begin
            n_fail++; $display("FAIL miss_cnt: got hit %0d miss %0d want %0d %0d", bus.hit_cnt, bus.miss_cnt, e_hit, e_miss); end
    endtask

    task automatic test_read_hit();
        obs_t o; bit h; logic [31:0] exp;
        drive_scored(1'b0, 32'h0000_1004, 32'h0, 3, o, h);
        n_chk++; exp = exp_q.pop_front(); if (o.rdata !== exp) begin n_fail++; $display("FAIL hit_rdata: got %h want %h", o.rdata, exp); end
        n_chk++; if (o.lat != 2) begin n_fail++; $display("FAIL hit_latency: got %0d want 2", o.lat); end
        n_chk++; if (o.mem !== 1'b0) begin n_fail++; $display("FAIL hit_no_mem: got %b want 0", o.mem); end
        n_chk++; if (o.after_ready !== 1'b0 || o.after_busy !== 1'b0) begin
            n_fail++; $display("FAIL hit_pulse: got ready %b busy %b want 0 0", o.after_ready, o.after_busy); end
        n_chk++; if (bus.hit_cnt !== 16'(e_hit)) begin n_fail++; $display("FAIL hit_cnt: got %0d want %0d", bus.hit_cnt, e_hit); end
    endtask

    task automatic test_write_through();
        obs_t o; bit h; logic [31:0] exp;
        drive_scored(1'b1, 32'h0000_1004, 32'h1234_5678, 4, o, h);
        n_chk++; if (o.cmp_we !== 1'b1) begin n_fail++; $display("FAIL wr_hit_data_we: got %b want 1", o.cmp_we); end
        n_chk++; if (o.mem !== 1'b1 || o.mem_we !== 1'b1 || o.unstable !== 1'b0) begin
            n_fail++; $display("FAIL wr_mem: got req %b we %b unstable %b want 1 1 0", o.mem, o.mem_we, o.unstable); end
        n_chk++; if (o.ready !== 1'b1 || o.fill !== 1'b0) begin n_fail++; $display("FAIL wr_done: got ready %b fill %b want 1 0", o.ready, o.fill); end
        drive_scored(1'b0, 32'h0000_1004, 32'h0, 3, o, h);
        n_chk++; exp = exp_q.pop_front(); if (o.rdata !== exp) begin n_fail++; $display("FAIL wr_readback: got %h want %h", o.rdata, exp); end
        n_chk++; if (o.mem !== 1'b0 || o.lat != 2) begin n_fail++; $display("FAIL wr_readback_hit: got mem %b lat %0d want 0 2", o.mem, o.lat); end
        n_chk++; if (bus.hit_cnt !== 16'(e_hit)) begin n_fail++; $display("FAIL wr_hit_cnt: got %0d want %0d", bus.hit_cnt, e_hit); end
    endtask

    task automatic test_conflict();
        obs_t o; bit h; logic [31:0] exp; logic [31:0] b;
        b = 32'h0000_5004;
        memm[b[31:2]] = 32'hCAFE_F00D;
        drive_scored(1'b0, b, 32'h0, 2, o, h);
        n_chk++; exp = exp_q.pop_front(); if (o.rdata !== exp) begin n_fail++; $display("FAIL conf_rdata: got %h want %h", o.rdata, exp); end
        n_chk++; if (o.fill !== 1'b1 || o.fill_tag !== f_tag(b) || o.fill_idx != f_idx(b)) begin
            n_fail++; $display("FAIL conf_fill: got %b tag %h idx %0d want 1 %h %0d", o.fill, o.fill_tag, o.fill_idx, f_tag(b), f_idx(b)); end
        drive_scored(1'b0, 32'h0000_1004, 32'h0, 1, o, h);
        n_chk++; if (o.mem !== 1'b1 || o.fill !== 1'b1) begin n_fail++; $display("FAIL conf_reread_miss: got mem %b fill %b want 1 1", o.mem, o.fill); end
        n_chk++; exp = exp_q.pop_front(); if (o.rdata !== exp) begin n_fail++; $display("FAIL conf_reread_rdata: got %h want %h", o.rdata, exp); end
        n_chk++; if (bus.miss_cnt !== 16'(e_miss)) begin n_fail++; $display("FAIL conf_miss_cnt: got %0d want %0d", bus.miss_cnt, e_miss); end
    endtask

    task automatic test_write_miss();
        obs_t o; bit h; logic [31:0] exp;
        drive_scored(1'b1, 32'h0000_2008, 32'hA5A5_0001, 2, o, h);
        n_chk++; if (o.cmp_we !== 1'b0 || o.fill !== 1'b0) begin n_fail++; $display("FAIL wmiss_no_ram: got data_we %b fill %b want 0 0", o.cmp_we, o.fill); end
        n_chk++; if (o.mem_we !== 1'b1 || o.mem_addr !== 32'h0000_2008) begin
            n_fail++; $display("FAIL wmiss_mem: got we %b addr %h want 1 00002008", o.mem_we, o.mem_addr); end
        drive_scored(1'b0, 32'h0000_2008, 32'h0, 2, o, h);
        n_chk++; if (o.mem !== 1'b1) begin n_fail++; $display("FAIL wmiss_no_alloc: got mem %b want 1", o.mem); end
        n_chk++; exp = exp_q.pop_front(); if (o.rdata !== exp) begin n_fail++; $display("FAIL wmiss_rdata: got %h want %h", o.rdata, exp); end
    endtask

    task automatic test_flush_priority();
        obs_t o; bit h; logic [31:0] exp;
        int cnt, bad;
        while (bus.busy) begin @(posedge clk); #1; end
        @(negedge clk);
        bus.cpu_flush = 1'b1; bus.cpu_req = 1'b1; bus.cpu_addr = 32'h0000_5004;
        @(posedge clk); #1;
        bus.cpu_flush = 1'b0; bus.cpu_req = 1'b0;
        cnt = 0; bad = 0;
        while (bus.busy && cnt < 5000) begin
            if (bus.valid_we !== 1'b1 || bus.mem_req !== 1'b0 || bus.cpu_ready !== 1'b0) bad++;
            @(posedge clk); #1; cnt++;
        end
        mvalid.delete();
        n_chk++; if (cnt != SWEEP || bad != 0) begin n_fail++; $display("FAIL flush_sweep: got %0d cycles %0d bad want %0d 0", cnt, bad, SWEEP); end
        n_chk++; if (bus.miss_cnt !== 16'(e_miss) || bus.hit_cnt !== 16'(e_hit)) begin
            n_fail++; $display("FAIL flush_drop: got hit %0d miss %0d want %0d %0d", bus.hit_cnt, bus.miss_cnt, e_hit, e_miss); end
        drive_scored(1'b0, 32'h0000_1004, 32'h0, 2, o, h);
        n_chk++; if (o.mem !== 1'b1 || o.fill !== 1'b1) begin n_fail++; $display("FAIL flush_then_miss: got mem %b fill %b want 1 1", o.mem, o.fill); end
        n_chk++; exp = exp_q.pop_front(); if (o.rdata !== exp) begin n_fail++; $display("FAIL flush_rdata: got %h want %h", o.rdata, exp); end
    endtask

    task automatic test_back_to_back();
        obs_t o; bit h; logic [31:0] exp; logic [31:0] a; logic w;
        logic [31:0] pool [5];
        pool[0] = 32'h0000_1004; pool[1] = 32'h0000_5004; pool[2] = 32'h0000_2008;
        pool[3] = 32'h0000_300C; pool[4] = 32'h0004_300C;
        for (int k = 0; k < 16; k++) begin
            a = pool[$urandom_range(0, 4)];
            w = ($urandom_range(0, 3) == 0);
            drive_scored(w, a, $urandom, $urandom_range(1, 4), o, h);
            n_chk++; if (o.ready !== 1'b1 || o.after_ready !== 1'b0) begin
                n_fail++; $display("FAIL b2b_ready[%0d]: got %b then %b want 1 then 0", k, o.ready, o.after_ready); end
            n_chk++; if (o.mem !== (w | !h)) begin n_fail++; $display("FAIL b2b_mem[%0d]: got %b want %b", k, o.mem, w | !h); end
            if (!w) begin
                n_chk++; exp = exp_q.pop_front();
                if (o.rdata !== exp) begin n_fail++; $display("FAIL b2b_rdata[%0d]: got %h want %h", k, o.rdata, exp); end
            end
        end
        n_chk++; if (bus.hit_cnt !== 16'(e_hit) || bus.miss_cnt !== 16'(e_miss)) begin
            n_fail++; $display("FAIL b2b_cnt: got hit %0d miss %0d want %0d %0d", bus.hit_cnt, bus.miss_cnt, e_hit, e_miss); end
    endtask

    task automatic test_reset_mid();
        int cnt, rdy;
        while (bus.busy) begin @(posedge clk); #1; end
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0009_0010;
        @(posedge clk); #1;
        bus.cpu_req = 1'b0;
        cnt = 0;
        while (!bus.mem_req && cnt < 20) begin @(posedge clk); #1; cnt++; end
        n_chk++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL rmid_reach_mem_rd: got %b want 1", bus.mem_req); end
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        n_chk++; if (bus.mem_req !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL rmid_async: got mem_req %b busy %b want 0 1", bus.mem_req, bus.busy); end
        n_chk++; if (bus.hit_cnt !== 16'h0 || bus.miss_cnt !== 16'h0 || bus.cpu_rdata !== 32'h0) begin
            n_fail++; $display("FAIL rmid_clear: got hit %0d miss %0d rdata %h want 0 0 0", bus.hit_cnt, bus.miss_cnt, bus.cpu_rdata); end
        rdy = 0;
        for (int i = 0; i < 4; i++) begin @(posedge clk); #1; if (bus.cpu_ready !== 1'b0 || bus.mem_req !== 1'b0) rdy++; end
        @(negedge clk); reset_n = 1'b1;
        mvalid.delete(); e_hit = 0; e_miss = 0;
        cnt = 0;
        while (bus.busy && cnt < 5000) begin
            if (bus.cpu_ready !== 1'b0) rdy++;
            @(posedge clk); #1; cnt++;
        end
        n_chk++; if (rdy != 0) begin n_fail++; $display("FAIL rmid_no_ready: got %0d bad cycles want 0", rdy); end
        n_chk++; if (cnt != SWEEP) begin n_fail++; $display("FAIL rmid_resweep: got %0d want %0d", cnt, SWEEP); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0;
        bus.cpu_wdata = 32'h0; bus.cpu_flush = 1'b0;
        bus.mem_rdata = 32'h0; bus.mem_ack = 1'b0;
        test_reset();
        test_read_miss_fill();
        test_read_hit();
        test_write_through();
        test_conflict();
        test_write_miss();
        test_flush_priority();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end

endmodule
